// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round count, rcon and the
// GF(2^8) arithmetic behind the forward and inverse S-boxes.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} aes_state_e;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES-128 forward/inverse round plus one forward and one inverse
// key-schedule step; lives beside the sequencer, which owns all registers.
module aes_round_unit (
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         inv,
    input  logic         last,
    input  logic [127:0] key_cur,
    input  logic [3:0]   rcon_idx,
    output logic [127:0] result,
    output logic [127:0] key_next,
    output logic [127:0] key_prev
);
    import aes_pkg::*;

    // Byte i sits at row i%4, column i/4, with byte 0 in the top bits.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic iv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = iv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic iv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = iv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic iv);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        coef[0] = iv ? 8'h0e : 8'h02;
        coef[1] = iv ? 8'h0b : 8'h03;
        coef[2] = iv ? 8'h0d : 8'h01;
        coef[3] = iv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], coef[(k + 4 - r) % 4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [3:0] idx);
        return {sbox(w[23:16]) ^ rcon(idx), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    logic [127:0] fwd_sr;
    logic [127:0] inv_ark;
    logic [31:0]  p3, p2, p1, n0, n1, n2;

    always_comb begin
        fwd_sr  = shift_rows(sub_bytes(state, 1'b0), 1'b0);
        inv_ark = sub_bytes(shift_rows(state, 1'b1), 1'b1) ^ round_key;
        if (inv)
            result = last ? inv_ark : mix_columns(inv_ark, 1'b1);
        else
            result = (last ? fwd_sr : mix_columns(fwd_sr, 1'b0)) ^ round_key;
    end

    // Inverse expansion recovers words 3..1 first, since word 0 depends on the old word 3.
    always_comb begin
        n0       = key_cur[127:96] ^ sub_rot(key_cur[31:0], rcon_idx);
        n1       = key_cur[95:64] ^ n0;
        n2       = key_cur[63:32] ^ n1;
        key_next = {n0, n1, n2, key_cur[31:0] ^ n2};
        p3       = key_cur[31:0] ^ key_cur[63:32];
        p2       = key_cur[63:32] ^ key_cur[95:64];
        p1       = key_cur[95:64] ^ key_cur[127:96];
        key_prev = {key_cur[127:96] ^ sub_rot(p3, rcon_idx), p1, p2, p3};
    end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 sequencer: owns the state and round-key registers and steps
// one round per clock through an external round unit and key-schedule unit.
module aes_iter_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic          iDecrypt,
    input  logic [127:0]  iKey,
    input  logic [127:0]  iData,
    output logic          oValid,
    input  logic          iReady,
    output logic [127:0]  oData,
    output logic          oBusy,
    output logic [127:0]  oRndState,
    output logic [127:0]  oRndKey,
    output logic          oRndInv,
    output logic          oRndLast,
    input  logic [127:0]  iRndResult,
    output logic [127:0]  oKeyCur,
    output logic [RW-1:0] oRconIdx,
    input  logic [127:0]  iKeyNext,
    input  logic [127:0]  iKeyPrev
);
    import aes_pkg::*;

    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    aes_state_e    fsm;
    logic [RW-1:0] rnd;
    logic [127:0]  data_reg;
    logic [127:0]  key_reg;
    logic          decrypt;

    assign oRndState = data_reg;
    assign oKeyCur   = key_reg;
    assign oRndInv   = decrypt;
    assign oRndKey   = decrypt ? iKeyPrev : iKeyNext;
    assign oRndLast  = (fsm == ROUND) && (rnd == LAST_RND);

    // Decryption walks the key schedule backwards, so rcon indices count down.
    always_comb begin
        oRconIdx = rnd;
        if (fsm == ROUND && decrypt)
            oRconIdx = RW'(NR + 1) - rnd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            rnd      <= '0;
            data_reg <= '0;
            key_reg  <= '0;
            decrypt  <= 1'b0;
            oValid   <= 1'b0;
            oBusy    <= 1'b0;
            oReady   <= 1'b1;
            oData    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (iValid && oReady) begin
                        decrypt <= iDecrypt;
                        key_reg <= iKey;
                        rnd     <= RW'(1);
                        oReady  <= 1'b0;
                        oBusy   <= 1'b1;
                        if (iDecrypt) begin
                            data_reg <= iData;
                            fsm      <= KEXP;
                        end else begin
                            data_reg <= iData ^ iKey;
                            fsm      <= ROUND;
                        end
                    end
                end
                // Run the schedule forward to K10, then whiten with it before inverse rounds.
                KEXP: begin
                    key_reg <= iKeyNext;
                    if (rnd == LAST_RND) begin
                        data_reg <= data_reg ^ iKeyNext;
                        rnd      <= RW'(1);
                        fsm      <= ROUND;
                    end else begin
                        rnd <= rnd + RW'(1);
                    end
                end
                ROUND: begin
                    data_reg <= iRndResult;
                    key_reg  <= oRndKey;
                    if (rnd == LAST_RND) begin
                        oData  <= iRndResult;
                        oValid <= 1'b1;
                        oBusy  <= 1'b0;
                        fsm    <= DONE;
                    end else begin
                        rnd <= rnd + RW'(1);
                    end
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                        rnd    <= '0;
                        fsm    <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench: sequencer plus round unit closed into a full AES-128 engine,
// checked against FIPS-197 vectors, latency, rcon order, backpressure and reset.
module tb_aes_iter_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RT_KEY   = 128'h31323334353637383930313233343536;
    localparam logic [127:0] RT_PT    = 128'h30393837363534333231363534333231;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iValid = 1'b0;
    logic         oReady;
    logic         iDecrypt = 1'b0;
    logic [127:0] iKey = '0;
    logic [127:0] iData = '0;
    logic         oValid;
    logic         iReady = 1'b0;
    logic [127:0] oData;
    logic         oBusy;
    logic [127:0] oRndState;
    logic [127:0] oRndKey;
    logic         oRndInv;
    logic         oRndLast;
    logic [127:0] iRndResult;
    logic [127:0] oKeyCur;
    logic [3:0]   oRconIdx;
    logic [127:0] iKeyNext;
    logic [127:0] iKeyPrev;

    int           n_pass = 0;
    int           n_total = 0;
    logic [127:0] job_res;
    int           job_lat;
    int           job_last_cnt;
    int           job_last_pos;
    logic [3:0]   rcon_seq [64];

    always #5 clk = ~clk;

    aes_iter_ctrl #(.NR(10), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady),
        .iDecrypt(iDecrypt), .iKey(iKey), .iData(iData), .oValid(oValid),
        .iReady(iReady), .oData(oData), .oBusy(oBusy), .oRndState(oRndState),
        .oRndKey(oRndKey), .oRndInv(oRndInv), .oRndLast(oRndLast),
        .iRndResult(iRndResult), .oKeyCur(oKeyCur), .oRconIdx(oRconIdx),
        .iKeyNext(iKeyNext), .iKeyPrev(iKeyPrev)
    );

    aes_round_unit round_unit (
        .state(oRndState), .round_key(oRndKey), .inv(oRndInv), .last(oRndLast),
        .key_cur(oKeyCur), .rcon_idx(oRconIdx), .result(iRndResult),
        .key_next(iKeyNext), .key_prev(iKeyPrev)
    );

    // Accepts one job, then counts edges (accept edge = 1) until oValid shows up.
    task automatic run_job(input logic dec, input logic [127:0] k, input logic [127:0] d,
                           input int pulse_a, input int pulse_b);
        @(negedge clk);
        iValid = 1'b1; iDecrypt = dec; iKey = k; iData = d;
        @(posedge clk); #1;
        iValid = 1'b0; iDecrypt = ~dec; iKey = ~k; iData = ~d;
        job_lat = 1; job_last_cnt = 0; job_last_pos = 0;
        while (oValid !== 1'b1 && job_lat < 60) begin
            rcon_seq[job_lat] = oRconIdx;
            if (oRndLast === 1'b1) begin
                job_last_cnt++;
                job_last_pos = job_lat;
            end
            iValid = (job_lat == pulse_a || job_lat == pulse_b);
            @(posedge clk); #1;
            iValid = 1'b0;
            job_lat++;
        end
        job_res = oData;
    endtask

    task automatic release_result(input string name);
        @(negedge clk); iReady = 1'b1;
        @(posedge clk); #1; iReady = 1'b0;
        n_total++;
        if (oValid !== 1'b0 || oReady !== 1'b1)
            $display("[TB] FAIL %s_release: oValid=%b oReady=%b, required 0/1", name, oValid, oReady);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (oReady !== 1'b1) $display("[TB] FAIL reset_ready: got %b, required 1", oReady);
        else n_pass++;
        n_total++;
        if (oValid !== 1'b0 || oBusy !== 1'b0)
            $display("[TB] FAIL reset_flags: oValid=%b oBusy=%b, required 0/0", oValid, oBusy);
        else n_pass++;
        n_total++;
        if (oData !== 128'h0) $display("[TB] FAIL reset_data: got %h, required 0", oData);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_encrypt_fips;
        run_job(1'b0, FIPS_KEY, FIPS_PT, 0, 0);
        n_total++;
        if (job_res !== FIPS_CT) $display("[TB] FAIL enc_data: got %h, required %h", job_res, FIPS_CT);
        else n_pass++;
        n_total++;
        if (job_lat != 11) $display("[TB] FAIL enc_latency: got %0d, required 11", job_lat);
        else n_pass++;
        n_total++;
        if (job_last_cnt != 1 || job_last_pos != 10)
            $display("[TB] FAIL enc_last: count %0d at %0d, required 1 at 10", job_last_cnt, job_last_pos);
        else n_pass++;
        release_result("enc");
    endtask

    task automatic test_decrypt_fips;
        logic [3:0] exp_idx;
        run_job(1'b1, FIPS_KEY, FIPS_CT, 0, 0);
        n_total++;
        if (job_res !== FIPS_PT) $display("[TB] FAIL dec_data: got %h, required %h", job_res, FIPS_PT);
        else n_pass++;
        n_total++;
        if (job_lat != 21) $display("[TB] FAIL dec_latency: got %0d, required 21", job_lat);
        else n_pass++;
        n_total++;
        if (job_last_cnt != 1 || job_last_pos != 20)
            $display("[TB] FAIL dec_last: count %0d at %0d, required 1 at 20", job_last_cnt, job_last_pos);
        else n_pass++;
        for (int i = 1; i <= 20; i++) begin
            exp_idx = (i <= 10) ? 4'(i) : 4'(21 - i);
            n_total++;
            if (rcon_seq[i] !== exp_idx)
                $display("[TB] FAIL dec_rcon_%0d: got %0d, required %0d", i, rcon_seq[i], exp_idx);
            else n_pass++;
        end
        release_result("dec");
    endtask

    task automatic test_round_trip;
        logic [127:0] ct;
        run_job(1'b0, RT_KEY, RT_PT, 0, 0);
        ct = job_res;
        n_total++;
        if (ct === RT_PT) $display("[TB] FAIL rt_enc_changed: got %h, required != plaintext", ct);
        else n_pass++;
        release_result("rt_enc");
        run_job(1'b1, RT_KEY, ct, 0, 0);
        n_total++;
        if (job_res !== RT_PT) $display("[TB] FAIL rt_dec: got %h, required %h", job_res, RT_PT);
        else n_pass++;
        release_result("rt_dec");
    endtask

    task automatic test_backpressure;
        run_job(1'b0, FIPS_KEY, FIPS_PT, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (oValid !== 1'b1 || oReady !== 1'b0 || oData !== FIPS_CT)
                $display("[TB] FAIL bp_hold_%0d: oValid=%b oReady=%b oData=%h, required 1/0/%h",
                         i, oValid, oReady, oData, FIPS_CT);
            else n_pass++;
        end
        release_result("bp");
    endtask

    task automatic test_busy_rejection;
        run_job(1'b0, FIPS_KEY, FIPS_PT, 3, 7);
        n_total++;
        if (job_res !== FIPS_CT || job_lat != 11)
            $display("[TB] FAIL busy_result: got %h after %0d, required %h after 11", job_res, job_lat, FIPS_CT);
        else n_pass++;
        release_result("busy");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (oBusy !== 1'b0 || oValid !== 1'b0 || oReady !== 1'b1)
                $display("[TB] FAIL busy_no_second_%0d: oBusy=%b oValid=%b oReady=%b, required 0/0/1",
                         i, oBusy, oValid, oReady);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_op;
        bit seen_valid;
        @(negedge clk);
        iValid = 1'b1; iDecrypt = 1'b0; iKey = FIPS_KEY; iData = FIPS_PT;
        @(posedge clk); #1;
        iValid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        n_total++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0)
            $display("[TB] FAIL rst_mid_flags: oReady=%b oValid=%b oBusy=%b, required 1/0/0",
                     oReady, oValid, oBusy);
        else n_pass++;
        n_total++;
        if (oData !== 128'h0) $display("[TB] FAIL rst_mid_data: got %h, required 0", oData);
        else n_pass++;
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (oValid === 1'b1) seen_valid = 1'b1;
        end
        n_total++;
        if (seen_valid) $display("[TB] FAIL rst_mid_no_result: oValid seen 1, required never");
        else n_pass++;
        run_job(1'b0, FIPS_KEY, FIPS_PT, 0, 0);
        n_total++;
        if (job_res !== FIPS_CT || job_lat != 11)
            $display("[TB] FAIL rst_mid_rerun: got %h after %0d, required %h after 11", job_res, job_lat, FIPS_CT);
        else n_pass++;
        release_result("rst_mid");
    endtask

    initial begin
        test_reset();
        test_encrypt_fips();
        test_decrypt_fips();
        test_round_trip();
        test_backpressure();
        test_busy_rejection();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
